sid_voice_sched: RTL and testbench

- Time-multiplexes the shared voice datapath (waveform selector + DCA pipeline) across all voice slots of two SID instances.
- On each sample tick, issues one voice slot per cycle and strobes the datapath `active` input.
- Captures the delayed DCA and OSC results into a shadow bank, then publishes all voices atomically with a one-cycle valid pulse.
- Guarantees exactly NUM_SLOTS `active` cycles per round, which keeps the datapath's per-slot delay lines (waveform-0 value/age) aligned.

---
 rtl/sid_voice_sched.sv | 141 ++++++++++++++
 tb/tb_sid_voice_sched.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sid_voice_sched.sv
// sid_voice_sched: time-multiplexes the shared voice datapath over both SIDs' slots; optional SID_VOICE_SCHED_MUTE_EN adds per-slot mute
module sid_voice_sched #(
  parameter int NUM_SLOTS = 6,
  parameter int LAT       = 1,
  parameter int SLOT_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick_i,
  input  logic                      model0_i,
  input  logic                      model1_i,
  output logic                      active_o,
  output logic [SLOT_W-1:0]         slot_o,
  output logic                      model_o,
  input  logic [21:0]               voice_res_i,
  input  logic [7:0]                osc_i,
`ifdef SID_VOICE_SCHED_MUTE_EN
  input  logic [NUM_SLOTS-1:0]      mute_i,
`endif
  output logic [22*NUM_SLOTS-1:0]   voices_o,
  output logic [15:0]               osc3_o,
  output logic                      valid_o,
  output logic                      busy_o,
  output logic                      overrun_o,
  input  logic                      overrun_clr_i
);
  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [SLOT_W-1:0] MID  = SLOT_W'(NUM_SLOTS / 2 - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
  state_e                   state_q, state_d;
  logic [SLOT_W-1:0]        slot_q, slot_d;
  logic [DW-1:0]            dcnt_q, dcnt_d;
  logic                     active_q, active_d;
  logic                     valid_q, valid_d;
  logic                     ovr_q, ovr_d;
  logic [LAT-1:0]           pv_q, pv_d;
  logic [SLOT_W-1:0]        ps_q [LAT];
  logic [SLOT_W-1:0]        ps_d [LAT];
  logic [21:0]              shadow_q [NUM_SLOTS];
  logic [21:0]              shadow_d [NUM_SLOTS];
  logic [7:0]               osc_lo_q, osc_lo_d, osc_hi_q, osc_hi_d;
  logic [22*NUM_SLOTS-1:0]  voices_q, voices_d;
  logic [15:0]              osc3_q, osc3_d;
  logic [SLOT_W-1:0]        cs;
  assign active_o  = active_q;
  assign slot_o    = slot_q;
  assign model_o   = (slot_q <= MID) ? model0_i : model1_i;
  assign voices_o  = voices_q;
  assign osc3_o    = osc3_q;
  assign valid_o   = valid_q;
  assign busy_o    = state_q != IDLE;
  assign overrun_o = ovr_q;
  assign cs        = ps_q[LAT-1];
  // next-state: round sequencing, capture pipe, shadow bank and atomic publish
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    dcnt_d   = dcnt_q;
    active_d = 1'b0;
    valid_d  = 1'b0;
    ovr_d    = (tick_i && state_q != IDLE) ? 1'b1 : overrun_clr_i ? 1'b0 : ovr_q;
    pv_d     = pv_q;
    ps_d     = ps_q;
    pv_d[0]  = active_q;
    ps_d[0]  = slot_q;
    for (int i = 1; i < LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      ps_d[i] = ps_q[i-1];
    end
    shadow_d = shadow_q;
    osc_lo_d = osc_lo_q;
    osc_hi_d = osc_hi_q;
    if (pv_q[LAT-1]) begin
`ifdef SID_VOICE_SCHED_MUTE_EN
      shadow_d[cs] = mute_i[cs] ? 22'd0 : voice_res_i;
`else
      shadow_d[cs] = voice_res_i;
`endif
      osc_lo_d = (cs == MID)  ? osc_i : osc_lo_q;
      osc_hi_d = (cs == LAST) ? osc_i : osc_hi_q;
    end
    unique case (state_q)
      IDLE: if (tick_i) begin
        state_d  = ISSUE;
        slot_d   = '0;
        active_d = 1'b1;
      end
      ISSUE: if (slot_q == LAST) begin
        state_d = DRAIN;
        dcnt_d  = '0;
      end else begin
        slot_d   = slot_q + 1'b1;
        active_d = 1'b1;
      end
      DRAIN: if (dcnt_q == DW'(LAT - 1)) begin
        state_d = IDLE;
        valid_d = 1'b1;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    voices_d = voices_q;
    if (valid_d)
      for (int k = 0; k < NUM_SLOTS; k++) voices_d[22*k +: 22] = shadow_d[k];
    osc3_d = valid_d ? {osc_hi_d, osc_lo_d} : osc3_q;
  end
  // state and output registers, all cleared on async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      dcnt_q   <= '0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      pv_q     <= '0;
      for (int i = 0; i < LAT; i++) ps_q[i] <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) shadow_q[k] <= '0;
      osc_lo_q <= '0;
      osc_hi_q <= '0;
      voices_q <= '0;
      osc3_q   <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      dcnt_q   <= dcnt_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      pv_q     <= pv_d;
      ps_q     <= ps_d;
      shadow_q <= shadow_d;
      osc_lo_q <= osc_lo_d;
      osc_hi_q <= osc_hi_d;
      voices_q <= voices_d;
      osc3_q   <= osc3_d;
    end
  end
endmodule

// File: tb/tb_sid_voice_sched.sv
// tb_sid_voice_sched: randomized scoreboard bench for sid_voice_sched with a one-cycle-latency datapath stand-in
module tb_sid_voice_sched;
  localparam int NS = 6, LAT = 1;
  logic clk = 0, rst_n = 0, tick_i = 0, model0_i = 0, model1_i = 1, overrun_clr_i = 0;
  logic active_o, model_o, valid_o, busy_o, overrun_o;
  logic [2:0] slot_o;
  logic [21:0] voice_res_i;
  logic [7:0] osc_i;
  logic [22*NS-1:0] voices_o;
  logic [15:0] osc3_o;
`ifdef SID_VOICE_SCHED_MUTE_EN
  logic [NS-1:0] mute = '0;
`endif
  sid_voice_sched dut (
    .clk(clk), .rst_n(rst_n), .tick_i(tick_i), .model0_i(model0_i), .model1_i(model1_i),
    .active_o(active_o), .slot_o(slot_o), .model_o(model_o),
    .voice_res_i(voice_res_i), .osc_i(osc_i),
`ifdef SID_VOICE_SCHED_MUTE_EN
    .mute_i(mute),
`endif
    .voices_o(voices_o), .osc3_o(osc3_o), .valid_o(valid_o), .busy_o(busy_o),
    .overrun_o(overrun_o), .overrun_clr_i(overrun_clr_i)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [21:0] rd_v [NS];
  logic [7:0]  rd_o [NS];
  logic [2:0]  dp_slot = 0;
  always @(posedge clk) if (active_o) dp_slot <= slot_o;
  assign voice_res_i = rd_v[dp_slot];
  assign osc_i       = rd_o[dp_slot];
  typedef struct {int c; logic [131:0] v; logic [15:0] o;} exp_t;
  exp_t q[$];
  exp_t me;
  int n_vec = 0, n_err = 0, free_at = 0, round_t = 0, ms;
  bit have_round = 0, det = 0, rnd_model = 0, ov_nxt = 0, exp_ov = 0;
  logic [131:0] last_v = '0;
  logic [15:0]  last_o = '0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) exp_ov <= 1'b0;
    else exp_ov <= ov_nxt;
  task automatic chk(string n, logic [131:0] a, logic [131:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic accept(int c);
    exp_t e;
    round_t = c;
    have_round = 1;
    free_at = c + NS + LAT + 1;
`ifdef SID_VOICE_SCHED_MUTE_EN
    mute = det ? 6'b000100 : 6'($urandom);
`endif
    e.c = free_at;
    e.v = '0;
    for (int k = 0; k < NS; k++) begin
      rd_v[k] = det ? 22'(k * 256) : 22'($urandom);
      rd_o[k] = det ? 8'(k + 'hA0) : 8'($urandom);
      e.v[22*k +: 22] = rd_v[k];
`ifdef SID_VOICE_SCHED_MUTE_EN
      if (mute[k]) e.v[22*k +: 22] = '0;
`endif
    end
    e.o = {rd_o[NS-1], rd_o[NS/2-1]};
    q.push_back(e);
  endtask
  task automatic step(bit t, bit clr);
    @(posedge clk);
    #1;
    tick_i = t;
    overrun_clr_i = clr;
    if (rnd_model) begin
      model0_i = 1'($urandom);
      model1_i = 1'($urandom);
    end
    if (t && cyc < free_at) ov_nxt = 1;
    else begin
      if (t) accept(cyc);
      if (clr) ov_nxt = 0;
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 0;
    tick_i = 0;
    overrun_clr_i = 0;
    have_round = 0;
    q.delete();
    free_at = 0;
    ov_nxt = 0;
    last_v = '0;
    last_o = '0;
    #1;
    chk("rst_active", 132'(active_o), 132'(0));
    chk("rst_slot", 132'(slot_o), 132'(0));
    chk("rst_valid", 132'(valid_o), 132'(0));
    chk("rst_busy", 132'(busy_o), 132'(0));
    chk("rst_overrun", 132'(overrun_o), 132'(0));
    chk("rst_voices", voices_o, 132'(0));
    chk("rst_osc3", 132'(osc3_o), 132'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1;
  endtask
  // monitor: per-cycle timing checks plus scoreboard pop on each publish
  always @(negedge clk) begin
    ms = cyc - round_t - 1;
    chk("active", 132'(active_o), 132'(have_round && cyc > round_t && cyc <= round_t + NS));
    chk("busy", 132'(busy_o), 132'(have_round && cyc > round_t && cyc <= round_t + NS + LAT));
    chk("overrun", 132'(overrun_o), 132'(exp_ov));
    if (have_round && cyc > round_t && cyc <= round_t + NS) begin
      chk("slot", 132'(slot_o), 132'(ms));
      chk("model", 132'(model_o), 132'(ms < NS / 2 ? model0_i : model1_i));
    end
    if (valid_o) begin
      if (q.size() == 0) chk("valid_spurious", 132'(1), 132'(0));
      else begin
        me = q.pop_front();
        chk("valid_cycle", 132'(cyc), 132'(me.c));
        chk("voices", voices_o, me.v);
        chk("osc3", 132'(osc3_o), 132'(me.o));
        last_v = me.v;
        last_o = me.o;
      end
    end else begin
      if (q.size() != 0 && q[0].c == cyc) chk("valid_missing", 132'(0), 132'(1));
      chk("voices_hold", voices_o, last_v);
      chk("osc3_hold", 132'(osc3_o), 132'(last_o));
    end
  end
  initial begin
    for (int k = 0; k < NS; k++) begin
      rd_v[k] = '0;
      rd_o[k] = '0;
    end
    do_reset();
    det = 1;
    step(1, 0);
    repeat (10) step(0, 0);
    det = 0;
    step(1, 0);
    repeat (3) step(0, 0);
    step(1, 0);
    step(0, 1);
    repeat (2) step(0, 0);
    step(1, 0);
    repeat (10) step(0, 0);
    step(1, 0);
    repeat (3) step(0, 0);
    do_reset();
    step(1, 0);
    repeat (10) step(0, 0);
    rnd_model = 1;
    repeat (5) begin
      step(1, 0);
      repeat (7) step(0, 0);
    end
    repeat (400) step($urandom_range(3) == 0, $urandom_range(7) == 0);
    repeat (12) step(0, 0);
    chk("queue_empty", 132'(q.size()), 132'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
